// File: rtl/clk_divider_pkg.sv
// ---------------------------------------------------------------------------
// clk_divider_pkg
//   Shared helpers for the clock divider.
//   calc_cw : width of a counter that must hold 0 .. div-1 (never below 1).
// ---------------------------------------------------------------------------
package clk_divider_pkg;

    function automatic int calc_cw(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_divider.sv
// ---------------------------------------------------------------------------
// clk_divider
//   Parameterised integer clock divider. Produces a registered square wave
//   clk_div of period DIV = CLK_IN / CLK_OUT system clocks (low for LO
//   cycles, then high for HI cycles) plus a one-cycle tick in the first
//   high cycle of each period, so consumers can stay on clk.
//
//   Parameters
//     CLK_IN   input clock frequency in Hz
//     CLK_OUT  requested output frequency in Hz (truncating division)
//
//   Ports
//     clk      in   system clock, rising edge
//     res      in   synchronous reset, active-high
//     clk_div  out  divided clock, registered
//     tick     out  single-cycle strobe on each clk_div rise
// ---------------------------------------------------------------------------
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int CLK_IN  = 20_000_000,
    parameter int CLK_OUT = 1_000
) (
    input  logic clk,
    input  logic res,
    output logic clk_div,
    output logic tick
);

    // Guard the division so a zero CLK_OUT reaches the elaboration check
    // instead of failing inside the constant expression.
    localparam int DIV = (CLK_OUT > 0) ? (CLK_IN / CLK_OUT) : 0;
    localparam int LO  = DIV / 2;
    localparam int HI  = DIV - LO;
    localparam int CW  = calc_cw(DIV);

    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] C_LO   = CW'(LO);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    generate
        if (CLK_IN <= 0 || CLK_OUT <= 0 || DIV < 2 || HI < LO) begin : g_bad_params
            $fatal(1, "clk_divider: CLK_IN/CLK_OUT must be positive with CLK_IN/CLK_OUT >= 2");
        end
    endgenerate

    logic [CW-1:0] r_cnt;
    logic          r_clk_div;
    logic          r_tick;
    logic [CW-1:0] w_cnt_next;

    // Wrap at DIV-1; the falling edge of clk_div lands on the wrap.
    always_comb begin
        w_cnt_next = (r_cnt == C_LAST) ? '0 : (r_cnt + C_ONE);
    end

    // Outputs are computed from the next count so they stay registered and
    // line up with the counter: clk_div == (cnt >= LO), tick == (cnt == LO).
    always_ff @(posedge clk) begin
        if (res) begin
            r_cnt     <= '0;
            r_clk_div <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_clk_div <= (w_cnt_next >= C_LO);
            r_tick    <= (w_cnt_next == C_LO);
        end
    end

    assign clk_div = r_clk_div;
    assign tick    = r_tick;

endmodule

// File: tb/tb_clk_divider.sv
// ---------------------------------------------------------------------------
// tb_clk_divider
//   Five divider instances with different ratios share one clock, each with
//   its own reset. Expected waveforms come from the ratio rules: a period of
//   DIV cycles made of LO low cycles followed by HI high cycles, tick in the
//   first high cycle, tick spacing of exactly DIV cycles.
// ---------------------------------------------------------------------------
module tb_clk_divider;

    logic       clk;
    logic [4:0] res_v;
    logic [4:0] cd_v;
    logic [4:0] tk_v;

    int vectors;
    int miscompares;

    // Ratios of the instances below: 10/1, 7/1, 2/1, 20/3 (truncated), default.
    int divs [5] = '{10, 7, 2, 6, 20000};
    int pos       [5];   // phase within the period after the last edge
    int since_rst [5];   // edges since reset release
    int last_tick [5];   // since_rst value of the previous tick, -1 if none

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial res_v = '1;

    clk_divider #(.CLK_IN(10), .CLK_OUT(1)) u_d10 (
        .clk(clk), .res(res_v[0]), .clk_div(cd_v[0]), .tick(tk_v[0]));
    clk_divider #(.CLK_IN(7),  .CLK_OUT(1)) u_d7 (
        .clk(clk), .res(res_v[1]), .clk_div(cd_v[1]), .tick(tk_v[1]));
    clk_divider #(.CLK_IN(2),  .CLK_OUT(1)) u_d2 (
        .clk(clk), .res(res_v[2]), .clk_div(cd_v[2]), .tick(tk_v[2]));
    clk_divider #(.CLK_IN(20), .CLK_OUT(3)) u_d6 (
        .clk(clk), .res(res_v[3]), .clk_div(cd_v[3]), .tick(tk_v[3]));
    clk_divider u_def (
        .clk(clk), .res(res_v[4]), .clk_div(cd_v[4]), .tick(tk_v[4]));

    // Hold one instance in reset for ncyc edges, checking the reset state
    // after every edge, then release it and restart its model.
    task automatic apply_reset(input int idx, input int ncyc, input string name);
        res_v[idx] = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (cd_v[idx] !== 1'b0) begin
                miscompares++;
                $display("FAIL %s reset clk_div inst %0d: got %b want 0", name, idx, cd_v[idx]);
            end
            vectors++;
            if (tk_v[idx] !== 1'b0) begin
                miscompares++;
                $display("FAIL %s reset tick inst %0d: got %b want 0", name, idx, tk_v[idx]);
            end
        end
        res_v[idx]     = 1'b0;
        pos[idx]       = 0;
        since_rst[idx] = 0;
        last_tick[idx] = -1;
    endtask

    // Run ncyc edges and compare against the ideal waveform.
    task automatic run_and_check(input int idx, input int ncyc, input string name);
        int   div;
        int   lo;
        int   hi;
        logic pat[$];
        logic exp_cd;
        logic exp_tk;
        div = divs[idx];
        lo  = div / 2;
        hi  = div - lo;
        for (int i = 0; i < lo; i++) pat.push_back(1'b0);
        for (int i = 0; i < hi; i++) pat.push_back(1'b1);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            pos[idx] = (pos[idx] + 1) % div;
            since_rst[idx]++;
            exp_cd = pat[pos[idx]];
            exp_tk = pat[pos[idx]] && !pat[(pos[idx] + div - 1) % div];
            vectors++;
            if (cd_v[idx] !== exp_cd) begin
                miscompares++;
                $display("FAIL %s clk_div inst %0d edge %0d: got %b want %b",
                         name, idx, since_rst[idx], cd_v[idx], exp_cd);
            end
            vectors++;
            if (tk_v[idx] !== exp_tk) begin
                miscompares++;
                $display("FAIL %s tick inst %0d edge %0d: got %b want %b",
                         name, idx, since_rst[idx], tk_v[idx], exp_tk);
            end
            if (tk_v[idx] === 1'b1) begin
                vectors++;
                if (last_tick[idx] >= 0) begin
                    if (since_rst[idx] - last_tick[idx] != div) begin
                        miscompares++;
                        $display("FAIL %s tick spacing inst %0d: got %0d want %0d",
                                 name, idx, since_rst[idx] - last_tick[idx], div);
                    end
                end else if (since_rst[idx] != lo) begin
                    miscompares++;
                    $display("FAIL %s first rise inst %0d: got edge %0d want edge %0d",
                             name, idx, since_rst[idx], lo);
                end
                last_tick[idx] = since_rst[idx];
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            res_v[i] = 1'b1;
        end
        // all instances are in reset together; check each after two edges
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (cd_v[i] !== 1'b0 || tk_v[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state inst %0d: got clk_div=%b tick=%b want 0 0",
                         i, cd_v[i], tk_v[i]);
            end
        end
    endtask

    task automatic test_div10();
        apply_reset(0, 3, "div10");
        run_and_check(0, 200, "div10");
    endtask

    task automatic test_div7_odd();
        apply_reset(1, 2, "div7");
        run_and_check(1, 70, "div7");
    endtask

    task automatic test_div2();
        apply_reset(2, 1, "div2");
        run_and_check(2, 20, "div2");
    endtask

    task automatic test_div6_trunc();
        apply_reset(3, 2, "div6");
        run_and_check(3, 60, "div6");
    endtask

    // Reset while clk_div is high (phase 7 of 10), then expect a fresh low phase.
    task automatic test_mid_reset();
        apply_reset(0, 2, "mid_reset");
        run_and_check(0, 7, "mid_reset");
        vectors++;
        if (cd_v[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset precondition clk_div: got %b want 1", cd_v[0]);
        end
        apply_reset(0, 1, "mid_reset");
        run_and_check(0, 25, "mid_reset");
    endtask

    // Random reset points and run lengths on the small ratios.
    task automatic test_random();
        int idx;
        for (int it = 0; it < 8; it++) begin
            idx = $urandom_range(0, 3);
            apply_reset(idx, $urandom_range(1, 3), "random");
            run_and_check(idx, $urandom_range(1, 40), "random");
            apply_reset(idx, 1, "random");
            run_and_check(idx, $urandom_range(20, 40), "random");
        end
    endtask

    // 20 MHz -> 1 kHz: first rise at edge 10000, ticks 20000 apart.
    task automatic test_defaults();
        apply_reset(4, 3, "defaults");
        run_and_check(4, 51000, "defaults");
        vectors++;
        if (last_tick[4] != 50000) begin
            miscompares++;
            $display("FAIL defaults tick count: last tick at edge %0d want 50000", last_tick[4]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_div10();
        test_div7_odd();
        test_div2();
        test_div6_trunc();
        test_mid_reset();
        test_random();
        test_defaults();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
